shiftregister_burst: RTL

Parametrised successor of the team's shift register. Executes multi-cycle shift/rotate commands of a programmable length, accepted through a valid/ready command handshake, with busy/done status. Sits as a datapath element driven by a control FSM. Formal assertions are bound the same way as for the single-step block.

---
 rtl/shiftregister_burst_pkg.sv | 24 ++
 rtl/shiftregister_burst_step.sv | 26 ++
 rtl/shiftregister_burst.sv | 114 +++++++++++
 3 files changed

// File: rtl/shiftregister_burst_pkg.sv
// Shared types for the burst shift register: command modes and controller states.
package shiftregister_burst_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_shift(input mode_t mode);
    return (mode inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR});
  endfunction

endpackage

// File: rtl/shiftregister_burst_step.sv
// Combinational single-step shift/rotate; non-shift modes pass the value through.
module shiftregister_burst_step
  import shiftregister_burst_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic [DATASIZE-1:0] value,
  input  mode_t               mode,
  input  logic                ser_in_msb,
  input  logic                ser_in_lsb,
  output logic [DATASIZE-1:0] next_value
);

  always_comb begin
    next_value = value;
    case (mode)
      MODE_SHL: next_value = {value[DATASIZE-2:0], ser_in_lsb};
      MODE_SHR: next_value = {ser_in_msb, value[DATASIZE-1:1]};
      MODE_ROL: next_value = {value[DATASIZE-2:0], value[DATASIZE-1]};
      MODE_ROR: next_value = {value[0], value[DATASIZE-1:1]};
      MODE_ASR: next_value = {value[DATASIZE-1], value[DATASIZE-1:1]};
      default:  next_value = value;
    endcase
  end

endmodule

// File: rtl/shiftregister_burst.sv
// Multi-cycle shift/rotate register with valid/ready command handshake.
// Optional abort input enabled by defining SHIFTREG_BURST_ABORT_EN.
//
// state | meaning
// IDLE  | ready for a command; LOAD/HOLD/zero-count complete here in one edge
// BUSY  | stepping the latched mode once per edge until remaining reaches 1
module shiftregister_burst
  import shiftregister_burst_pkg::*;
#(
  parameter int DATASIZE  = 8,
  parameter int COUNTSIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           mode_i,
  input  logic [COUNTSIZE-1:0] count_i,
  input  logic [DATASIZE-1:0]  load_value_i,
  input  logic                 ser_in_msb_i,
  input  logic                 ser_in_lsb_i,
`ifdef SHIFTREG_BURST_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic [DATASIZE-1:0]  value_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_t               state_q, state_d;
  mode_t                mode_q, mode_d;
  logic [COUNTSIZE-1:0] remaining_q, remaining_d;
  logic [DATASIZE-1:0]  value_q, value_d, step_value;
  logic                 done_q, done_d;
  logic                 abort;
  mode_t                cmd_mode;

  assign cmd_mode = mode_t'(mode_i);

`ifdef SHIFTREG_BURST_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif

  shiftregister_burst_step #(.DATASIZE(DATASIZE)) u_step (
    .value      (value_q),
    .mode       (mode_q),
    .ser_in_msb (ser_in_msb_i),
    .ser_in_lsb (ser_in_lsb_i),
    .next_value (step_value)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mode_q      <= MODE_HOLD;
      remaining_q <= '0;
      value_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
      value_q     <= value_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remaining_d = remaining_q;
    value_d     = value_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_mode == MODE_LOAD) begin
            value_d = load_value_i;
            done_d  = 1'b1;
          end else if (is_shift(cmd_mode) && (count_i != '0)) begin
            mode_d      = cmd_mode;
            remaining_d = count_i;
            state_d     = BUSY;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          // Partial result is kept; an aborted burst never reports done.
          remaining_d = '0;
          state_d     = IDLE;
        end else begin
          value_d     = step_value;
          remaining_d = remaining_q - COUNTSIZE'(1);
          if (remaining_q == COUNTSIZE'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == BUSY);
  assign value_o     = value_q;
  assign done_o      = done_q;

endmodule
